// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// uart_prog_loader : 8N1 UART receiver that packs little-endian 32-bit words
//                    and writes them through the upg_* programming port.
// Revision 1.0
// ============================================================================
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 104,
  parameter int WORDS_TOTAL  = 32768,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  input  logic        rx,
  output logic [14:0] upg_adr,
  output logic [31:0] upg_dat,
  output logic        upg_wen,
  output logic        upg_done,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [14:0]   WORD_LAST = 15'(WORDS_TOTAL - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} ctrl_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_e;

  ctrl_e          ctrl_q, ctrl_d;
  rx_e            rstate_q, rstate_d;
  logic           rx_meta_q, rx_sync_q, start_q;
  logic [CW-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [1:0]     byte_idx_q, byte_idx_d;
  logic [23:0]    asm_q, asm_d;
  logic [14:0]    word_idx_q, word_idx_d;
  logic           got_byte_q, got_byte_d;
  logic [TW-1:0]  to_cnt_q, to_cnt_d;
  logic [14:0]    adr_q, adr_d;
  logic [31:0]    dat_q, dat_d;
  logic           wen_q, wen_d;
  logic           err_q, err_d;

  logic           arm;
  logic           stop_smp;
  logic           byte_ok;
  logic           frame_bad;

  assign arm       = start & ~start_q;
  assign byte_ok   = stop_smp & rx_sync_q;
  assign frame_bad = stop_smp & ~rx_sync_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      ctrl_q     <= S_IDLE;
      rstate_q   <= R_IDLE;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      start_q    <= 1'b0;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      word_idx_q <= '0;
      got_byte_q <= 1'b0;
      to_cnt_q   <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      wen_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      rstate_q   <= rstate_d;
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      start_q    <= start;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      word_idx_q <= word_idx_d;
      got_byte_q <= got_byte_d;
      to_cnt_q   <= to_cnt_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      wen_q      <= wen_d;
      err_q      <= err_d;
    end
  end

  // Receiver: start bit re-checked at mid-bit, then one sample per bit period.
  always_comb begin
    rstate_d  = rstate_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    stop_smp  = 1'b0;
    if (ctrl_q != S_LOAD) begin
      rstate_d  = R_IDLE;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          if (!rx_sync_q) rstate_d = R_START;
        end
        R_START: begin
          if (clk_cnt_q == HALF_LAST) begin
            clk_cnt_d = '0;
            rstate_d  = rx_sync_q ? R_IDLE : R_DATA;
          end else begin
            clk_cnt_d = clk_cnt_q + 1'b1;
          end
        end
        R_DATA: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_d = '0;
            shift_d   = {rx_sync_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) rstate_d = R_STOP;
          end else begin
            clk_cnt_d = clk_cnt_q + 1'b1;
          end
        end
        R_STOP: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_d = '0;
            stop_smp  = 1'b1;
            rstate_d  = R_IDLE;
          end else begin
            clk_cnt_d = clk_cnt_q + 1'b1;
          end
        end
        default: rstate_d = R_IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    word_idx_d = word_idx_q;
    got_byte_d = got_byte_q;
    to_cnt_d   = to_cnt_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    wen_d      = 1'b0;
    err_d      = err_q;
    case (ctrl_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          ctrl_d     = S_LOAD;
          byte_idx_d = '0;
          word_idx_d = '0;
          got_byte_d = 1'b0;
          to_cnt_d   = '0;
          err_d      = 1'b0;
        end
      end
      S_LOAD: begin
        if (byte_ok) begin
          case (byte_idx_q)
            2'd0: asm_d[7:0]   = shift_q;
            2'd1: asm_d[15:8]  = shift_q;
            2'd2: asm_d[23:16] = shift_q;
            default: begin
              dat_d = {shift_q, asm_q};
              adr_d = word_idx_q;
              wen_d = 1'b1;
            end
          endcase
          byte_idx_d = byte_idx_q + 1'b1;
        end
        if (frame_bad) err_d = 1'b1;
        // Index advances the cycle after the strobe; last word ends the load.
        if (wen_q) begin
          word_idx_d = word_idx_q + 1'b1;
          if (word_idx_q == WORD_LAST) ctrl_d = S_DONE;
        end
        if (stop_smp) begin
          to_cnt_d   = '0;
          got_byte_d = 1'b1;
        end else if (got_byte_q && rstate_q == R_IDLE) begin
          if (to_cnt_q == TO_LAST) begin
            ctrl_d     = S_DONE;
            byte_idx_d = '0;
            if (byte_idx_q != 2'd0) err_d = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end
      default: ctrl_d = S_IDLE;
    endcase
  end

  assign upg_adr  = adr_q;
  assign upg_dat  = dat_q;
  assign upg_wen  = wen_q;
  assign upg_done = (ctrl_q == S_DONE);
  assign busy     = (ctrl_q == S_LOAD);
  assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`default_nettype none
// ============================================================================
// tb_uart_prog_loader : directed self-checking bench for uart_prog_loader.
// Revision 1.0
// ============================================================================
module tb_uart_prog_loader;

  localparam int CPB = 4;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        start8 = 1'b0;
  logic        rx    = 1'b1;

  logic [14:0] adr, adr8;
  logic [31:0] dat, dat8;
  logic        wen, wen8, done, done8, busy, busy8, err, err8;

  always #5 clock = ~clock;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .WORDS_TOTAL(2), .TIMEOUT_CLKS(64)) dut (
    .clock(clock), .rst(rst), .start(start), .rx(rx),
    .upg_adr(adr), .upg_dat(dat), .upg_wen(wen), .upg_done(done),
    .busy(busy), .err(err)
  );

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .WORDS_TOTAL(8), .TIMEOUT_CLKS(64)) dut8 (
    .clock(clock), .rst(rst), .start(start8), .rx(rx),
    .upg_adr(adr8), .upg_dat(dat8), .upg_wen(wen8), .upg_done(done8),
    .busy(busy8), .err(err8)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [14:0] s_adr[$];
  logic [31:0] s_dat[$];
  int          s_cyc[$];
  logic [14:0] s8_adr[$];
  logic [31:0] s8_dat[$];
  int          done_cyc = -1;
  logic        busy_at_done = 1'b1;
  logic        done_prev = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (wen) begin
      s_adr.push_back(adr);
      s_dat.push_back(dat);
      s_cyc.push_back(cyc);
    end
    if (wen8) begin
      s8_adr.push_back(adr8);
      s8_dat.push_back(dat8);
    end
    if (done && !done_prev) begin
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    done_prev = done;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    if (!stop_bit) repeat (CPB) @(negedge clock);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (3) @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    s_adr.delete(); s_dat.delete(); s_cyc.delete();
    s8_adr.delete(); s8_dat.delete();
    done_cyc = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check_eq("rst_adr",  {17'd0, adr}, 32'd0);
    check_eq("rst_dat",  dat, 32'd0);
    check_eq("rst_wen",  {31'd0, wen}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_err",  {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(negedge clock);

    // rx traffic while idle is ignored
    send_byte(8'h55, 1'b1);
    repeat (5) @(negedge clock);
    check_eq("idle_no_wen",  s_adr.size(), 0);
    check_eq("idle_busy",    {31'd0, busy}, 32'd0);

    // Two-word load
    pulse_start();
    check_eq("load_busy", {31'd0, busy}, 32'd1);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    repeat (10) @(negedge clock);
    check_eq("load_nstrobe", s_adr.size(), 2);
    if (s_adr.size() >= 2) begin
      check_eq("load_adr0", {17'd0, s_adr[0]}, 32'd0);
      check_eq("load_dat0", s_dat[0], 32'h12345678);
      check_eq("load_adr1", {17'd0, s_adr[1]}, 32'd1);
      check_eq("load_dat1", s_dat[1], 32'hDEADBEEF);
      check_eq("done_lat",  done_cyc - s_cyc[1], 1);
    end
    check_eq("done_busy_fall", {31'd0, busy_at_done}, 32'd0);
    check_eq("load_done", {31'd0, done}, 32'd1);
    check_eq("load_err",  {31'd0, err}, 32'd0);
    check_eq("held_dat",  dat, 32'hDEADBEEF);

    // Traffic in DONE is ignored
    send_byte(8'h99, 1'b1);
    repeat (5) @(negedge clock);
    check_eq("done_ignore", s_adr.size(), 2);

    // Re-arm from DONE
    s_adr.delete(); s_dat.delete(); s_cyc.delete();
    pulse_start();
    check_eq("rearm_done", {31'd0, done}, 32'd0);
    check_eq("rearm_busy", {31'd0, busy}, 32'd1);
    send_word(32'hD4C3B2A1);
    repeat (5) @(negedge clock);
    check_eq("rearm_n", s_adr.size(), 1);
    if (s_adr.size() >= 1) begin
      check_eq("rearm_adr", {17'd0, s_adr[0]}, 32'd0);
      check_eq("rearm_dat", s_dat[0], 32'hD4C3B2A1);
    end
    do_reset();

    // Single-cycle glitch must not register as a byte
    pulse_start();
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    repeat (20) @(negedge clock);
    check_eq("glitch_err", {31'd0, err}, 32'd0);
    send_word(32'h40302010);
    repeat (5) @(negedge clock);
    check_eq("glitch_n", s_adr.size(), 1);
    if (s_adr.size() >= 1) check_eq("glitch_dat", s_dat[0], 32'h40302010);
    do_reset();

    // Framing error: byte dropped, err sticky
    pulse_start();
    send_byte(8'hAA, 1'b0);
    check_eq("frame_err", {31'd0, err}, 32'd1);
    send_word(32'h44332211);
    repeat (5) @(negedge clock);
    check_eq("frame_n", s_adr.size(), 1);
    if (s_adr.size() >= 1) begin
      check_eq("frame_adr", {17'd0, s_adr[0]}, 32'd0);
      check_eq("frame_dat", s_dat[0], 32'h44332211);
    end
    check_eq("frame_err_hold", {31'd0, err}, 32'd1);
    do_reset();

    // Reset mid-word, then a fresh word
    pulse_start();
    send_byte(8'hC1, 1'b1);
    send_byte(8'hC2, 1'b1);
    check_eq("midrst_prestrobe", s_adr.size(), 0);
    rst = 1'b1;
    repeat (2) @(negedge clock);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clock);
    check_eq("midrst_nostrobe", s_adr.size(), 0);
    pulse_start();
    send_word(32'h8D7C6B5A);
    repeat (5) @(negedge clock);
    check_eq("midrst_n", s_adr.size(), 1);
    if (s_adr.size() >= 1) begin
      check_eq("midrst_adr", {17'd0, s_adr[0]}, 32'd0);
      check_eq("midrst_dat", s_dat[0], 32'h8D7C6B5A);
    end
    check_eq("dut8_idle_ignore", s8_adr.size(), 0);
    do_reset();

    // Timeout with a partial word (8-word instance)
    start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
    repeat (2) @(negedge clock);
    for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b1);
    repeat (40) @(negedge clock);
    check_eq("to_early_done", {31'd0, done8}, 32'd0);
    check_eq("to_n", s8_adr.size(), 1);
    if (s8_adr.size() >= 1) begin
      check_eq("to_adr", {17'd0, s8_adr[0]}, 32'd0);
      check_eq("to_dat", s8_dat[0], 32'h04030201);
    end
    for (int t = 0; t < 200 && !done8; t++) @(negedge clock);
    check_eq("to_done", {31'd0, done8}, 32'd1);
    check_eq("to_err",  {31'd0, err8}, 32'd1);
    check_eq("to_busy", {31'd0, busy8}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Serial program/data loader that feeds the upg_* programming port of instruction ROM and data RAM.
- Receives 8N1 UART bytes, assembles little-endian 32-bit words and issues one write strobe per word with an auto-incrementing 15-bit word address.
- Address bit 14 selects the target: 0 = instruction ROM, 1 = data RAM.
- Signals completion through upg_done, which releases the CPU from programming mode.

Parameters:
- CLKS_PER_BIT, 104: clock cycles per UART bit. Minimum 4.
- WORDS_TOTAL, 32768: number of words that completes a load. Range 1..32768.
- TIMEOUT_CLKS, 1000000: idle cycles after the last stop bit that terminate a load early.

Ports:
- clock  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  arm request, level input. Its rising edge is detected internally.
- rx  in  1  UART serial input, idle high, asynchronous to clock.
- upg_adr  out  15  word address for the current write.
- upg_dat  out  32  assembled word.
- upg_wen  out  1  one-cycle write strobe.
- upg_done  out  1  load finished. Stays high until re-armed or reset.
- busy  out  1  high while in LOAD.
- err  out  1  sticky error flag: framing error or partial word at timeout.

Behaviour:
- Reset values: upg_adr=0, upg_dat=0, upg_wen=0, upg_done=0, busy=0, err=0. All FSMs return to idle. Byte index and word index are cleared.
- rx passes through a 2-flop synchronizer before use; add 2 cycles of input latency.
- start is registered once; its rising edge is the arm event.
- Control FSM has three states:
  - IDLE: on arm event go to LOAD. Clear word index, byte index, err and the timeout counter.
  - LOAD: busy=1, receiver enabled.
  - DONE: upg_done=1, busy=0. An arm event re-enters LOAD and clears upg_done in the same cycle.
  - An arm event while in LOAD is ignored.
- Receiver FSM (active only in LOAD):
  - R_IDLE: a synchronized low moves to R_START.
  - R_START: at CLKS_PER_BIT/2, if rx is still low go to R_DATA; otherwise treat as a glitch and return to R_IDLE.
  - R_DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - R_STOP: sample after one more CLKS_PER_BIT. Stop bit 1 means the byte is valid. Stop bit 0 sets err and discards the byte; the byte index is not advanced.
  - Return to R_IDLE after the stop-bit sample. Back-to-back frames must be accepted.
- Word assembly:
  - Byte k (k = 0..3) is placed in upg_dat[8k+7:8k].
  - On the 4th valid byte: upg_dat takes the full word and upg_wen=1 for exactly one cycle, with upg_adr = current word index.
  - The word index increments in the cycle after the strobe.
  - upg_adr and upg_dat hold their values between strobes.
- Completion:
  - When the written word count reaches WORDS_TOTAL, go to DONE in the cycle after the final strobe.
  - Timeout: the counter resets at every stop-bit sample and counts only while at least one byte has been received in this load and the receiver is in R_IDLE. Reaching TIMEOUT_CLKS goes to DONE.
  - A nonzero byte index at timeout discards the partial word and sets err.
  - Before the first byte there is no timeout; the block waits indefinitely.
- Word index wrap: with WORDS_TOTAL=32768 the index never wraps. The final address is 0x7FFF and the load ends there.
- rst asserted mid-frame or mid-word: immediate return to IDLE. No further upg_wen. Partial data is lost.
- rx activity in IDLE or DONE is ignored; no strobes are issued.

Test Plan (CLKS_PER_BIT=4, TIMEOUT_CLKS=64, WORDS_TOTAL=2 unless stated):
- Reset then idle: all outputs 0. rx toggling without start produces no upg_wen.
- Pulse start, send bytes 0x78 0x56 0x34 0x12 0xEF 0xBE 0xAD 0xDE:
  - upg_wen at adr 0 with dat 0x12345678, then at adr 1 with 0xDEADBEEF.
  - upg_done rises in the cycle after the 2nd strobe; busy falls in the same cycle.
- WORDS_TOTAL=8, send 5 bytes (0x01..0x05), then idle:
  - One strobe: adr 0, dat 0x04030201.
  - After 64 idle cycles: upg_done=1 and err=1.
- Send 0xAA with stop bit 0, then 4 valid bytes 0x11 0x22 0x33 0x44: err=1, single strobe with dat 0x44332211 at adr 0.
- 1-cycle low glitch on rx in LOAD: no byte is recorded and err stays 0.
- Assert rst after 2 bytes, then re-arm and send a full word:
  - No strobe occurs before the reset.
  - After re-arm, the strobe is at adr 0 with only the new bytes.
- Re-arm from DONE: upg_done clears and the next strobe uses adr 0.
